// File: rtl/pll_pkg.sv
// Shared state encoding, lock threshold tables and the saturating |x| helper
// for the PLL lock detector.
package pll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACQ_FREQ  = 2'd1,
    ST_ACQ_PHASE = 2'd2,
    ST_LOCKED    = 2'd3
  } lock_state_e;

  // Element i is the threshold selected by freq_lock_range == i.
  localparam logic [3:0][15:0] FTHR = {16'd8, 16'd4, 16'd2, 16'd1};
  localparam logic [3:0][15:0] PTHR = {16'd256, 16'd64, 16'd16, 16'd4};

  // x is a w-bit signed value sign-extended to 32 bits; the most-negative
  // w-bit value maps to the largest positive one so the result fits w bits.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x,
                                          input int unsigned w);
    logic signed [31:0] lim;
    lim = 32'sd1 <<< (w - 1);
    if (x == -lim) return lim - 32'sd1;
    else if (x < 0) return -x;
    else return x;
  endfunction

endpackage

// File: rtl/pll_err_window.sv
// Phase-error window: accumulates saturated |err| over 2^WIN_LOG2 samples.
// win_done_o/mean_o flag the closing sample combinationally; win_mean_o holds the last mean.
module pll_err_window
  import pll_pkg::*;
#(
  parameter int ERR_W    = 16,
  parameter int WIN_LOG2 = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             vld_i,
  input  logic [ERR_W-1:0] err_i,
  output logic             win_done_o,
  output logic [ERR_W-1:0] mean_o,
  output logic [ERR_W-1:0] win_mean_o
);

  localparam int ACC_W = ERR_W + WIN_LOG2;

  logic [ERR_W-1:0]    abs_err;
  logic [ACC_W-1:0]    sum_q, sum_d;
  logic [WIN_LOG2-1:0] idx_q;
  logic [ERR_W-1:0]    win_mean_q;

  assign abs_err    = ERR_W'(sat_abs(32'(signed'(err_i)), ERR_W));
  assign sum_d      = sum_q + ACC_W'(abs_err);
  assign win_done_o = vld_i && !clear_i && (idx_q == '1);
  assign mean_o     = ERR_W'(sum_d >> WIN_LOG2);
  assign win_mean_o = win_mean_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q      <= '0;
      idx_q      <= '0;
      win_mean_q <= '0;
    end else if (clear_i) begin
      sum_q <= '0;
      idx_q <= '0;
    end else if (vld_i) begin
      if (win_done_o) begin
        sum_q      <= '0;
        win_mean_q <= mean_o;
      end else begin
        sum_q <= sum_d;
      end
      idx_q <= idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/pll_lock_detect.sv
// PLL lock detector: frequency then phase acquisition with hysteretic loss-of-lock, all outputs registered.
// Defining PLL_LOCK_STATS_EN builds the lost_count / peak_err statistics; otherwise they read 0.
module pll_lock_detect
  import pll_pkg::*;
#(
  parameter int ERR_W    = 16,
  parameter int WIN_LOG2 = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       freq_lock_range,
  input  logic [CNT_W-1:0] lock_target,
  input  logic             ferr_valid,
  input  logic [ERR_W-1:0] ferr,
  input  logic             pherr_valid,
  input  logic [ERR_W-1:0] pherr,
  output logic             freq_locked,
  output logic             phase_locked,
  output logic             lost_lock,
  output logic [1:0]       state,
  output logic [ERR_W-1:0] win_mean,
  output logic [15:0]      lost_count,
  output logic [ERR_W-1:0] peak_err
);

  localparam int THR_W = ERR_W + 1;

  lock_state_e      state_q;
  logic             fl_q, pl_q, lost_q;
  logic [CNT_W-1:0] fcnt_q, pcnt_q;

  logic [THR_W-1:0] ferr_abs, ft, ft2, pt, pt2, mean_ext;
  logic [CNT_W-1:0] target, fcnt_inc, pcnt_inc;
  logic             win_active, win_clear, win_done;
  logic [ERR_W-1:0] win_mean_nxt;
  logic             f_good, f_bad;

  assign ferr_abs = THR_W'(sat_abs(32'(signed'(ferr)), ERR_W));
  assign ft       = THR_W'(FTHR[freq_lock_range]);
  assign pt       = THR_W'(PTHR[freq_lock_range]);
  assign ft2      = ft << 1;
  assign pt2      = pt << 1;
  assign f_good   = ferr_valid && (ferr_abs <= ft);
  assign f_bad    = ferr_valid && (ferr_abs > ft2);
  assign mean_ext = THR_W'(win_mean_nxt);

  assign target   = (lock_target == '0) ? CNT_W'(1) : lock_target;
  assign fcnt_inc = (&fcnt_q) ? fcnt_q : fcnt_q + 1'b1;
  assign pcnt_inc = (&pcnt_q) ? pcnt_q : pcnt_q + 1'b1;

  // Window runs only in the phase states, so every entry from ACQ_FREQ starts at index 0.
  assign win_active = (state_q == ST_ACQ_PHASE) || (state_q == ST_LOCKED);
  assign win_clear  = !enable || !win_active;

  pll_err_window #(
    .ERR_W    (ERR_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_win (
    .clk_i      (clk_ref),
    .rst_i      (rst),
    .clear_i    (win_clear),
    .vld_i      (pherr_valid && win_active),
    .err_i      (pherr),
    .win_done_o (win_done),
    .mean_o     (win_mean_nxt),
    .win_mean_o (win_mean)
  );

  always_ff @(posedge clk_ref) begin
    if (rst || !enable) begin
      state_q <= ST_IDLE;
      fl_q    <= 1'b0;
      pl_q    <= 1'b0;
      lost_q  <= 1'b0;
      fcnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      lost_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          fcnt_q  <= '0;
          pcnt_q  <= '0;
          state_q <= ST_ACQ_FREQ;
        end
        ST_ACQ_FREQ: begin
          if (ferr_valid) begin
            if (!f_good) begin
              fcnt_q <= '0;
            end else if (fcnt_inc >= target) begin
              fcnt_q  <= fcnt_inc;
              pcnt_q  <= '0;
              fl_q    <= 1'b1;
              state_q <= ST_ACQ_PHASE;
            end else begin
              fcnt_q <= fcnt_inc;
            end
          end
        end
        ST_ACQ_PHASE: begin
          if (f_bad) begin
            state_q <= ST_ACQ_FREQ;
            fl_q    <= 1'b0;
            fcnt_q  <= '0;
            pcnt_q  <= '0;
            lost_q  <= 1'b1;
          end else if (win_done) begin
            if (mean_ext > pt) begin
              pcnt_q <= '0;
            end else if (pcnt_inc >= target) begin
              pcnt_q  <= pcnt_inc;
              pl_q    <= 1'b1;
              state_q <= ST_LOCKED;
            end else begin
              pcnt_q <= pcnt_inc;
            end
          end
        end
        ST_LOCKED: begin
          if (f_bad) begin
            state_q <= ST_ACQ_FREQ;
            fl_q    <= 1'b0;
            pl_q    <= 1'b0;
            fcnt_q  <= '0;
            pcnt_q  <= '0;
            lost_q  <= 1'b1;
          end else if (win_done && (mean_ext > pt2)) begin
            state_q <= ST_ACQ_PHASE;
            pl_q    <= 1'b0;
            pcnt_q  <= '0;
            lost_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state        = state_q;
  assign freq_locked  = fl_q;
  assign phase_locked = pl_q;
  assign lost_lock    = lost_q;

`ifdef PLL_LOCK_STATS_EN
  logic [15:0]      lost_cnt_q;
  logic [ERR_W-1:0] peak_q, ph_abs;
  logic             in_lock_q;

  assign ph_abs = ERR_W'(sat_abs(32'(signed'(pherr)), ERR_W));

  // Peak restarts on the first cycle spent in LOCKED.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      lost_cnt_q <= '0;
      peak_q     <= '0;
      in_lock_q  <= 1'b0;
    end else begin
      in_lock_q <= (state_q == ST_LOCKED);
      if (lost_q && !(&lost_cnt_q)) lost_cnt_q <= lost_cnt_q + 16'd1;
      if ((state_q == ST_LOCKED) && !in_lock_q) peak_q <= pherr_valid ? ph_abs : '0;
      else if (pherr_valid && (ph_abs > peak_q)) peak_q <= ph_abs;
    end
  end

  assign lost_count = lost_cnt_q;
  assign peak_err   = peak_q;
`else
  assign lost_count = '0;
  assign peak_err   = '0;
`endif

endmodule

// File: tb/tb_pll_lock_detect.sv
// Directed bench for pll_lock_detect: expected state/flags are queued as each
// sample is driven and popped for comparison after the clock edge.
module tb_pll_lock_detect;

  localparam int ERR_W    = 16;
  localparam int WIN_LOG2 = 4;
  localparam int CNT_W    = 8;
`ifdef PLL_LOCK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk_ref = 1'b0;
  logic             rst;
  logic             enable;
  logic [1:0]       freq_lock_range;
  logic [CNT_W-1:0] lock_target;
  logic             ferr_valid;
  logic [ERR_W-1:0] ferr;
  logic             pherr_valid;
  logic [ERR_W-1:0] pherr;
  logic             freq_locked, phase_locked, lost_lock;
  logic [1:0]       state;
  logic [ERR_W-1:0] win_mean, peak_err;
  logic [15:0]      lost_count;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       fl;
    logic       pl;
    logic       ll;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk_ref = ~clk_ref;

  pll_lock_detect #(
    .ERR_W    (ERR_W),
    .WIN_LOG2 (WIN_LOG2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_ref         (clk_ref),
    .rst             (rst),
    .enable          (enable),
    .freq_lock_range (freq_lock_range),
    .lock_target     (lock_target),
    .ferr_valid      (ferr_valid),
    .ferr            (ferr),
    .pherr_valid     (pherr_valid),
    .pherr           (pherr),
    .freq_locked     (freq_locked),
    .phase_locked    (phase_locked),
    .lost_lock       (lost_lock),
    .state           (state),
    .win_mean        (win_mean),
    .lost_count      (lost_count),
    .peak_err        (peak_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle of samples, queue the expected post-edge state, then compare.
  task automatic step(input string tag, input bit fv, input int f, input bit pv, input int p,
                      input logic [1:0] st, input bit fl, input bit pl, input bit ll);
    exp_t e;
    ferr_valid  = fv;
    ferr        = 16'(f);
    pherr_valid = pv;
    pherr       = 16'(p);
    exp_q.push_back('{tag, st, fl, pl, ll});
    @(posedge clk_ref);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, " state"}, 32'(state), 32'(e.st));
    chk({e.tag, " fl/pl/ll"}, 32'({freq_locked, phase_locked, lost_lock}),
        32'({e.fl, e.pl, e.ll}));
    ferr_valid  = 1'b0;
    pherr_valid = 1'b0;
  endtask

  // From ACQ_FREQ at range 1, target 4: four good ferr, then four windows of |10|.
  task automatic lock_up(input string tag);
    for (int i = 0; i < 4; i++)
      step({tag, " freq"}, 1'b1, 1, 1'b0, 0, (i == 3) ? 2'd2 : 2'd1, i == 3, 1'b0, 1'b0);
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 16; k++) begin
        bit last;
        last = (w == 3) && (k == 15);
        step({tag, " phase"}, 1'b0, 0, 1'b1, (k % 2 == 1) ? -10 : 10,
             last ? 2'd3 : 2'd2, 1'b1, last, 1'b0);
      end
      chk({tag, " win_mean"}, 32'(win_mean), 32'd10);
    end
  endtask

  initial begin
    rst             = 1'b1;
    enable          = 1'b1;
    freq_lock_range = 2'd1;
    lock_target     = 8'd4;
    ferr_valid      = 1'b0;
    ferr            = '0;
    pherr_valid     = 1'b0;
    pherr           = '0;

    repeat (3) @(posedge clk_ref);
    #1;
    chk("reset state", 32'(state), 32'd0);
    chk("reset flags", 32'({freq_locked, phase_locked, lost_lock}), 32'd0);
    chk("reset win_mean", 32'(win_mean), 32'd0);
    chk("reset lost_count", 32'(lost_count), 32'd0);
    chk("reset peak_err", 32'(peak_err), 32'd0);
    rst = 1'b0;
    step("leave idle", 1'b0, 0, 1'b0, 0, 2'd1, 1'b0, 1'b0, 1'b0);

    lock_up("lock1");

    step("hyst ferr=4", 1'b1, 4, 1'b0, 0, 2'd3, 1'b1, 1'b1, 1'b0);
    step("floss ferr=5", 1'b1, 5, 1'b0, 0, 2'd1, 1'b0, 1'b0, 1'b1);
    step("floss pulse end", 1'b0, 0, 1'b0, 0, 2'd1, 1'b0, 1'b0, 1'b0);

    lock_up("lock2");

    for (int k = 0; k < 16; k++)
      step("ploss", 1'b0, 0, 1'b1, 40, (k == 15) ? 2'd2 : 2'd3, 1'b1, k != 15, k == 15);
    chk("ploss win_mean", 32'(win_mean), 32'd40);
    chk("peak after ploss", 32'(peak_err), STATS ? 32'd40 : 32'd0);
    step("ploss pulse end", 1'b0, 0, 1'b0, 0, 2'd2, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++)
      step("most-negative", 1'b0, 0, 1'b1, -32768, 2'd2, 1'b1, 1'b0, 1'b0);
    chk("sat win_mean", 32'(win_mean), 32'd32767);
    chk("sat peak", 32'(peak_err), STATS ? 32'd32767 : 32'd0);

    step("acqp floss", 1'b1, -5, 1'b0, 0, 2'd1, 1'b0, 1'b0, 1'b1);
    step("acqp pulse end", 1'b0, 0, 1'b0, 0, 2'd1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++)
      step("refreq", 1'b1, -1, 1'b0, 0, (i == 3) ? 2'd2 : 2'd1, i == 3, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      step("partial win", 1'b0, 0, 1'b1, 100, 2'd2, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    step("disable", 1'b0, 0, 1'b1, 100, 2'd0, 1'b0, 1'b0, 1'b0);
    step("disabled hold", 1'b0, 0, 1'b0, 0, 2'd0, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    step("reenable", 1'b0, 0, 1'b0, 0, 2'd1, 1'b0, 1'b0, 1'b0);

    lock_target = 8'd0;
    step("target0 freq", 1'b1, 0, 1'b0, 0, 2'd2, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++)
      step("restart win", 1'b0, 0, 1'b1, 2, 2'd2, 1'b1, 1'b0, 1'b0);
    chk("win_mean held", 32'(win_mean), 32'd32767);
    step("restart win end", 1'b0, 0, 1'b1, -2, 2'd3, 1'b1, 1'b1, 1'b0);
    chk("restart win_mean", 32'(win_mean), 32'd2);
    step("locked idle", 1'b0, 0, 1'b0, 0, 2'd3, 1'b1, 1'b1, 1'b0);

    chk("lost_count", 32'(lost_count), STATS ? 32'd3 : 32'd0);
    chk("peak on relock", 32'(peak_err), 32'd0);
    chk("queue drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pll_lock_detect.md
# pll_lock_detect

Parametrised lock detector for the digital PLL, clocked by the reference clock. It consumes per-reference-cycle frequency-error and phase-error samples from the PLL core and runs a four-state acquisition FSM. It asserts `freq_locked` and `phase_locked` with programmable lock range and loss-of-lock hysteresis. It replaces bench-side phase-error bookkeeping with synthesizable hardware, and it sits beside the loop filter inside `pll`.

## Interface
- `ERR_W`, 16, width of signed phase and frequency error samples
- `WIN_LOG2`, 4, phase window length is 2^WIN_LOG2 samples
- `CNT_W`, 8, width of consecutive-good counters and `lock_target`
- `clk_ref` in 1: reference clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: detector run; low forces IDLE.
- `freq_lock_range` in 2: selects the threshold pair from the package tables.
- `lock_target` in CNT_W: consecutive good samples/windows required to advance (0 treated as 1).
- `ferr_valid` in 1: `ferr` valid this cycle.
- `ferr` in ERR_W: signed frequency error (measured minus expected divider count).
- `pherr_valid` in 1: `pherr` valid this cycle.
- `pherr` in ERR_W: signed phase error.
- `freq_locked` out 1
- `phase_locked` out 1
- `lost_lock` out 1: one-cycle pulse on any exit from LOCKED, or on an exit from ACQ_PHASE to ACQ_FREQ.
- `state` out 2: IDLE=0, ACQ_FREQ=1, ACQ_PHASE=2, LOCKED=3.
- `win_mean` out ERR_W: last completed window's mean |pherr|.
- `lost_count` out 16, `peak_err` out ERR_W: statistics outputs; see Configuration.

## Operation
- |x| saturates: the most-negative input maps to 2^(ERR_W-1)-1.
- Thresholds: FT = FTHR[range], PT = PTHR[range]. Unlock thresholds are 2·FT and 2·PT, computed in ERR_W+1 bits.
- IDLE: all counters cleared. Go to ACQ_FREQ when `enable`=1.
- ACQ_FREQ: on `ferr_valid`, if |ferr| ≤ FT, increment `fcnt` (saturating); otherwise clear it. When `fcnt` reaches `lock_target`, go to ACQ_PHASE and set `freq_locked`.
- ACQ_PHASE and LOCKED:
  - Window accumulator is ERR_W+WIN_LOG2 bits. On `pherr_valid` add |pherr| and increment the sample index.
  - On the 2^WIN_LOG2-th sample: `win_mean` = sum >> WIN_LOG2; clear the accumulator; the index wraps to 0.
- ACQ_PHASE:
  - At window end, if mean ≤ PT increment `pcnt`, else clear it. When `pcnt` reaches `lock_target`, go to LOCKED and set `phase_locked`.
  - If a `ferr` sample has |ferr| > 2·FT: go to ACQ_FREQ and pulse `lost_lock`.
- LOCKED:
  - If a `ferr` sample has |ferr| > 2·FT: go to ACQ_FREQ and clear both lock flags.
  - Otherwise, if the window mean > 2·PT: go to ACQ_PHASE and clear `phase_locked`.
  - Both exits pulse `lost_lock`.
- Both valids in one cycle: both samples are processed, and the frequency check has priority for the transition.
- `enable` low in any state: IDLE next cycle; flags, counters and accumulator cleared; no `lost_lock` pulse.
- `freq_lock_range` changing mid-operation takes effect on the next sample. Counters are not cleared.

## Timing
- Reset: `state`=IDLE and every output 0, including `win_mean` and the statistics outputs.
- All outputs are registered. A sample at cycle t affects `state` and the flags at t+1.
- `win_mean` updates the cycle after the last window sample, and the lock decision on that window is in the same cycle.
- Lock latency is at least `lock_target` ferr samples plus `lock_target`·2^WIN_LOG2 pherr samples.
- The window restarts at index 0 on every entry to ACQ_PHASE from ACQ_FREQ.
- Synchronous reset mid-window discards the partial sum.

## Configuration
- `PLL_LOCK_STATS_EN` defined:
  - `lost_count` is a 16-bit saturating count of `lost_lock` pulses, cleared only by `rst`.
  - `peak_err` holds the maximum |pherr| seen since `rst` or since entry to LOCKED.
- Undefined: both ports stay present and are driven constant 0, with no statistics logic.

## Structure
- `pll_pkg`:
  - State enum.
  - `FTHR` = {1,2,4,8} and `PTHR` = {4,16,64,256}, indexed by `freq_lock_range`.
  - Saturating-abs function.
- One sub-module, `pll_err_window`: abs, accumulate, index, and a `win_done`/`win_mean` output. Cleared by `clear`.
- FSM and counters live in `pll_lock_detect`.

## Test plan
- Reset sanity: hold `rst` 3 cycles with `enable`=1 → all outputs 0; `state`=1 the cycle after `rst` drops.
- Acquisition: range=1, `lock_target`=4, ferr=1 ×4 → `freq_locked` at the 5th edge.
  - Then pherr=±10 ×64 → `win_mean`=10 and `phase_locked` after the 4th window; `state`=3.
- Frequency loss: from LOCKED, one ferr=5 (> 2·2) → `state`=1, both flags 0, `lost_lock` high exactly 1 cycle.
  - A ferr=4 sample instead keeps LOCKED (hysteresis).
- Phase loss: from LOCKED at range=1, a window of pherr=40 (mean 40 > 32) → `state`=2, `freq_locked`=1, `phase_locked`=0, one `lost_lock` pulse.
- Boundary: pherr=-32768 ×16 → `win_mean`=32767 with no accumulator overflow. `enable` dropped mid-window → IDLE with no pulse; re-enable restarts from index 0.
- With `PLL_LOCK_STATS_EN`: 3 forced losses → `lost_count`=3, and `peak_err` tracks the largest |pherr|. Without it, both read 0.
